// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage controller.
// Owns the fetch PC and the exception PC. Drives the next-PC mux select and
// keeps the minimal status/cause state needed for exception entry and eret.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall_i            fetch hold (exceptions still accepted)
//   br_taken_i, j_i, jr_i, eret_i
//                      redirect requests, priority eret > jr > j > br
//   exc_req_i/exc_code_i/exc_pc_i
//                      synchronous exception, highest priority
//   int_req_i          level interrupt, gated by ie, ~exl and RUN state
//   sr_we_i/sr_ie_i    status (interrupt enable) write
//   pc_next_i          mux result for the select driven this cycle
//   pc_o, pc_inc_o     current word PC and PC+1 (mod 2^30)
//   pc_source_o        next-PC mux select, combinational
//   epc_o, cause_o, exl_o, ie_o
//                      exception state
//   flush_o            registered one-cycle kill of IF/ID after a redirect
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic        j_i,
  input  logic        jr_i,
  input  logic        eret_i,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic [29:0] exc_pc_i,
  input  logic        int_req_i,
  input  logic        sr_we_i,
  input  logic        sr_ie_i,
  input  logic [29:0] pc_next_i,
  output logic [29:0] pc_o,
  output logic [29:0] pc_inc_o,
  output logic [2:0]  pc_source_o,
  output logic [29:0] epc_o,
  output logic [4:0]  cause_o,
  output logic        exl_o,
  output logic        ie_o,
  output logic        flush_o
);
  // Next-PC mux select encodings
  localparam logic [2:0] PC_NORMAL = 3'd0;
  localparam logic [2:0] PC_ADD    = 3'd1;
  localparam logic [2:0] PC_J      = 3'd2;
  localparam logic [2:0] PC_JR     = 3'd3;
  localparam logic [2:0] PC_EPC    = 3'd4;
  localparam logic [2:0] PC_ERROR  = 3'd5;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]  state;
  logic [29:0] pc_q, epc_q;
  logic [4:0]  cause_q;
  logic        exl_q, ie_q, flush_q;
  logic        open_run, int_take, redirect;
  logic [2:0]  sel;

  // Non-exception requests are only looked at in RUN and when not stalled;
  // ignored requests are simply dropped, upstream re-presents them.
  assign open_run = (state == S_RUN) & ~stall_i;
  assign int_take = int_req_i & ie_q & ~exl_q & (state == S_RUN);

  always_comb begin
    sel = PC_NORMAL;
    if (exc_req_i)        sel = PC_ERROR;
    else if (open_run) begin
      if (int_take)       sel = PC_ERROR;
      else if (eret_i)    sel = PC_EPC;
      else if (jr_i)      sel = PC_JR;
      else if (j_i)       sel = PC_J;
      else if (br_taken_i) sel = PC_ADD;
    end
  end

  assign redirect = (sel != PC_NORMAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC[31:2];
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b0;
      flush_q <= 1'b0;
      state   <= S_RUN;
    end else begin
      // A stall freezes the PC except when an exception forces a redirect.
      if (redirect || !stall_i) pc_q <= pc_next_i;
      state   <= redirect ? S_FLUSH : S_RUN;
      flush_q <= redirect;
      if (exc_req_i) begin
        epc_q   <= exc_pc_i;
        cause_q <= exc_code_i;
        exl_q   <= 1'b1;
      end else if (sel == PC_ERROR) begin
        // interrupt: resume at the instruction that was about to be fetched
        epc_q   <= pc_q;
        cause_q <= 5'd0;
        exl_q   <= 1'b1;
      end else if (sel == PC_EPC) begin
        exl_q   <= 1'b0;
      end
      if (sr_we_i) ie_q <= sr_ie_i;
    end
  end

  assign pc_o        = pc_q;
  assign pc_inc_o    = pc_q + 30'd1;
  assign pc_source_o = sel;
  assign epc_o       = epc_q;
  assign cause_o     = cause_q;
  assign exl_o       = exl_q;
  assign ie_o        = ie_q;
  assign flush_o     = flush_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random traffic,
// checked against a behavioural model through select and state scoreboards.
module tb_pc_sequencer;
  localparam logic [2:0]  PC_NORMAL = 3'd0, PC_ADD = 3'd1, PC_J = 3'd2,
                          PC_JR = 3'd3, PC_EPC = 3'd4, PC_ERROR = 3'd5;
  localparam logic [29:0] VEC = 30'h0000_1060;

  logic        clk = 1'b0;
  logic        rst, stall_i, br_taken_i, j_i, jr_i, eret_i, exc_req_i;
  logic [4:0]  exc_code_i;
  logic [29:0] exc_pc_i;
  logic        int_req_i, sr_we_i, sr_ie_i;
  logic [29:0] pc_next_i, pc_o, pc_inc_o, epc_o;
  logic [2:0]  pc_source_o;
  logic [4:0]  cause_o;
  logic        exl_o, ie_o, flush_o;
  logic [29:0] tgt_add, tgt_j, tgt_jr;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i),
    .j_i(j_i), .jr_i(jr_i), .eret_i(eret_i), .exc_req_i(exc_req_i),
    .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .int_req_i(int_req_i),
    .sr_we_i(sr_we_i), .sr_ie_i(sr_ie_i), .pc_next_i(pc_next_i),
    .pc_o(pc_o), .pc_inc_o(pc_inc_o), .pc_source_o(pc_source_o),
    .epc_o(epc_o), .cause_o(cause_o), .exl_o(exl_o), .ie_o(ie_o),
    .flush_o(flush_o)
  );

  // Next-PC mux, as the datapath would build it around the sequencer.
  always_comb begin
    case (pc_source_o)
      PC_ADD:   pc_next_i = tgt_add;
      PC_J:     pc_next_i = tgt_j;
      PC_JR:    pc_next_i = tgt_jr;
      PC_EPC:   pc_next_i = epc_o;
      PC_ERROR: pc_next_i = VEC;
      default:  pc_next_i = pc_inc_o;
    endcase
  end

  typedef struct {
    logic [29:0] pc, epc;
    logic [4:0]  cause;
    logic        exl, ie, flush;
  } st_t;

  typedef struct {
    int          sel;   // -1: no select check this cycle (reset)
    logic [29:0] inc;
  } sx_t;

  st_t m;
  st_t st_q[$];
  sx_t sel_q[$];
  event ev_drive;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply one cycle of the sequencer rules to m.
  task automatic step();
    st_t n;
    sx_t sx;
    bit  accept;
    n = m;
    sx.sel = PC_NORMAL;
    sx.inc = m.pc + 30'd1;
    accept = !m.flush && !stall_i;   // window in which normal requests count
    if (rst) begin
      n.pc = 30'h0000_0C00; n.epc = 0; n.cause = 0;
      n.exl = 0; n.ie = 0; n.flush = 0;
      sx.sel = -1;
    end else begin
      n.flush = 1;
      if (exc_req_i) begin
        sx.sel = PC_ERROR; n.pc = VEC;
        n.epc = exc_pc_i; n.cause = exc_code_i; n.exl = 1;
      end else if (accept && int_req_i && m.ie && !m.exl) begin
        sx.sel = PC_ERROR; n.pc = VEC;
        n.epc = m.pc; n.cause = 0; n.exl = 1;
      end else if (accept && eret_i) begin
        sx.sel = PC_EPC; n.pc = m.epc; n.exl = 0;
      end else if (accept && jr_i) begin
        sx.sel = PC_JR; n.pc = tgt_jr;
      end else if (accept && j_i) begin
        sx.sel = PC_J; n.pc = tgt_j;
      end else if (accept && br_taken_i) begin
        sx.sel = PC_ADD; n.pc = tgt_add;
      end else begin
        n.flush = 0;
        n.pc = stall_i ? m.pc : m.pc + 30'd1;
      end
      if (sr_we_i) n.ie = sr_ie_i;
    end
    m = n;
    sel_q.push_back(sx);
    st_q.push_back(n);
    -> ev_drive;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; stall_i = 0; br_taken_i = 0; j_i = 0; jr_i = 0; eret_i = 0;
    exc_req_i = 0; exc_code_i = 0; exc_pc_i = 0; int_req_i = 0;
    sr_we_i = 0; sr_ie_i = 0;
  endtask

  // Select/increment monitor: combinational outputs, sampled mid-cycle.
  initial begin
    forever begin
      sx_t e;
      @(ev_drive);
      #2;
      if (sel_q.size() == 0) begin
        chk("sel_queue_underflow", 32'd0, 32'd1);
      end else begin
        e = sel_q.pop_front();
        if (e.sel >= 0) begin
          chk("pc_source", {29'd0, pc_source_o}, e.sel);
          chk("pc_inc", {2'd0, pc_inc_o}, {2'd0, e.inc});
        end
      end
    end
  end

  // State monitor: registered outputs, sampled just after the edge.
  initial begin
    forever begin
      st_t e;
      @(posedge clk);
      #1;
      if (st_q.size() != 0) begin
        e = st_q.pop_front();
        chk("pc", {2'd0, pc_o}, {2'd0, e.pc});
        chk("epc", {2'd0, epc_o}, {2'd0, e.epc});
        chk("cause", {27'd0, cause_o}, {27'd0, e.cause});
        chk("exl", {31'd0, exl_o}, {31'd0, e.exl});
        chk("ie", {31'd0, ie_o}, {31'd0, e.ie});
        chk("flush", {31'd0, flush_o}, {31'd0, e.flush});
      end
    end
  end

  initial begin
    tgt_add = 30'h0000_0C10; tgt_j = 30'h0000_0D00; tgt_jr = 30'h0000_0E00;
    idle();
    // reset, then free-run
    rst = 1; step(); step();
    rst = 0;
    repeat (4) step();
    // taken branch at C04, j ignored during the flush cycle
    br_taken_i = 1; step(); br_taken_i = 0;
    j_i = 1; step(); j_i = 0;
    step();
    // exception beats jr/br and a stall
    stall_i = 1; exc_req_i = 1; jr_i = 1; br_taken_i = 1;
    exc_pc_i = 30'h0000_0C08; exc_code_i = 5'd12;
    step(); idle();
    step();
    eret_i = 1; step(); eret_i = 0;
    step();
    // interrupt gating
    int_req_i = 1; step(); step();
    int_req_i = 0; sr_we_i = 1; sr_ie_i = 1; step(); sr_we_i = 0;
    int_req_i = 1; step(); step(); step();   // take, flush, no re-entry
    int_req_i = 0; eret_i = 1; step(); eret_i = 0;
    step();
    // exception inside FLUSH keeps flushing
    j_i = 1; step(); j_i = 0;
    exc_req_i = 1; exc_pc_i = 30'h0000_0ABC; exc_code_i = 5'd4; step(); idle();
    step(); step();
    // wrap
    tgt_j = 30'h3FFF_FFFE; j_i = 1; step(); j_i = 0;
    step(); step(); step();
    // reset during FLUSH
    j_i = 1; step(); j_i = 0;
    rst = 1; step(); rst = 0;
    step(); step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      stall_i    = ($urandom_range(0, 4) == 0);
      br_taken_i = ($urandom_range(0, 5) == 0);
      j_i        = ($urandom_range(0, 9) == 0);
      jr_i       = ($urandom_range(0, 11) == 0);
      eret_i     = ($urandom_range(0, 9) == 0);
      exc_req_i  = ($urandom_range(0, 19) == 0);
      exc_code_i = 5'($urandom());
      exc_pc_i   = 30'($urandom());
      int_req_i  = ($urandom_range(0, 2) == 0);
      sr_we_i    = ($urandom_range(0, 7) == 0);
      sr_ie_i    = 1'($urandom());
      tgt_add    = 30'($urandom());
      tgt_j      = ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF : 30'($urandom());
      tgt_jr     = 30'($urandom());
      step();
    end
    idle();
    step();
    @(posedge clk); #3;
    chk("sel_queue_drained", sel_q.size(), 32'd0);
    chk("state_queue_drained", st_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
